// File: rtl/bin2bcd_display_pkg.sv
// Shared types and helpers for the binary-to-BCD display converter.
package bin2bcd_display_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam logic [3:0] ERR_NIBBLE = 4'hE;

  // Double-dabble correction: a digit that would reach 10+ after doubling is pre-biased by 3.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_display_bcd_adjust.sv
// Combinational per-nibble add-3 corrector applied to the whole BCD shift register.
module bin2bcd_display_bcd_adjust
  import bin2bcd_display_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] raw,
  output logic [4*DIGITS-1:0] adj
);

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = add3(raw[4*i +: 4]);
    end
  end

endmodule

// File: rtl/bin2bcd_display.sv
// Iterative double-dabble converter producing a held, packed-nibble display word,
// with a one-cycle raw hex pass-through and sticky decimal overflow flag.
module bin2bcd_display
  import bin2bcd_display_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hex_mode,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   disp
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e          state;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]   bcd_sr;
  logic            ovf_acc;
  logic [CW-1:0]   cnt;

  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_next;
  logic [WIDTH-1:0] bin_next;
  logic            msb_out;
  logic            ovf_next;
  logic [BW-1:0]   hex_word;

  bin2bcd_display_bcd_adjust #(
    .DIGITS (DIGITS)
  ) u_bcd_adjust (
    .raw (bcd_sr),
    .adj (bcd_adj)
  );

  always_comb begin
    msb_out  = bcd_adj[BW-1];
    bcd_next = {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
    bin_next = {bin_sr[WIDTH-2:0], 1'b0};
    ovf_next = ovf_acc | msb_out;
    hex_word = BW'(value);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      disp    <= '0;
      cnt     <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      ovf_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (hex_mode) begin
              disp <= hex_word;
              ovf  <= 1'b0;
              done <= 1'b1;
            end else begin
              bin_sr  <= value;
              bcd_sr  <= '0;
              ovf_acc <= 1'b0;
              cnt     <= CW'(WIDTH);
              state   <= SHIFT;
              busy    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bin_sr  <= bin_next;
          bcd_sr  <= bcd_next;
          ovf_acc <= ovf_next;
          cnt     <= cnt - CW'(1);
          // Final shift: publish result, substituting the error pattern on overflow.
          if (cnt == CW'(1)) begin
            disp  <= ovf_next ? {DIGITS{ERR_NIBBLE}} : bcd_next;
            ovf   <= ovf_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench: driver queues expected results, monitor checks on every done pulse.
module tb_bin2bcd_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hex_mode = 1'b0;
  logic [31:0] value = '0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] disp;

  typedef struct {
    logic [31:0] disp;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bin2bcd_display #(
    .WIDTH  (32),
    .DIGITS (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hex_mode (hex_mode),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .disp     (disp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 disp=%h", disp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("disp", disp, e.disp);
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  // Drive start for one edge; called right after a posedge (+1).
  task automatic issue(input logic hm, input logic [31:0] v, input logic [31:0] exp_disp,
                       input logic exp_ovf);
    exp_t e;
    e.disp = exp_disp;
    e.ovf  = exp_ovf;
    sb.push_back(e);
    start    = 1'b1;
    hex_mode = hm;
    value    = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    hex_mode = 1'b0;
    value    = 32'hA5A5_A5A5;
  endtask

  // Counts edges with the start edge as edge 1; returns with done visible (or timeout).
  task automatic wait_done(output int n, output int busy_cyc, output bit disp_moved);
    logic [31:0] prev;
    prev       = disp;
    n          = 1;
    busy_cyc   = 0;
    disp_moved = 1'b0;
    while (!done && n < 100) begin
      if (busy) busy_cyc++;
      if (disp !== prev) disp_moved = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  int n, bc;
  bit moved;

  initial begin
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_disp", disp, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 32'd0, 32'h0000_0000, 1'b0);
    wait_done(n, bc, moved);
    check("latency_zero", n, 32'd33);
    check("busy_cycles", bc, 32'd32);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);

    issue(1'b0, 32'd12345678, 32'h1234_5678, 1'b0);
    wait_done(n, bc, moved);
    check("disp_held_during_conv", {31'd0, moved}, 32'd0);
    @(posedge clk);
    #1;

    issue(1'b0, 32'd99999999, 32'h9999_9999, 1'b0);
    wait_done(n, bc, moved);
    @(posedge clk);
    #1;
    issue(1'b0, 32'd100000000, 32'hEEEE_EEEE, 1'b1);
    wait_done(n, bc, moved);
    @(posedge clk);
    #1;
    issue(1'b0, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b1);
    wait_done(n, bc, moved);
    @(posedge clk);
    #1;

    // Hex pass-through: result on the accepting edge, busy never raised, ovf cleared.
    issue(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    check("hex_done", {31'd0, done}, 32'd1);
    check("hex_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("hex_busy_next", {31'd0, busy}, 32'd0);

    // Second start at cycle 10 must be dropped, not queued.
    issue(1'b0, 32'd5, 32'h0000_0005, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    value = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bc, moved);
    // Start held in the done cycle is accepted.
    issue(1'b0, 32'd42, 32'h0000_0042, 1'b0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n, bc, moved);
    check("b2b_latency", n, 32'd33);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_ignored", {31'd0, busy}, 32'd0);

    // Async reset mid-conversion after a result with ovf set.
    issue(1'b0, 32'd100000000, 32'hEEEE_EEEE, 1'b1);
    wait_done(n, bc, moved);
    @(posedge clk);
    #1;
    start = 1'b1;
    value = 32'd777;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    check("arst_disp", disp, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 32'd255, 32'h0000_0255, 1'b0);
    wait_done(n, bc, moved);
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
